// File: rtl/rallybike_pkg.sv
// Shared types and defaults for the 68K-side bus logic.
package rallybike_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROM_WAIT,
        ST_SHR_WAIT,
        ST_COUNT,
        ST_ACK
    } bus_state_t;

    localparam int DEF_RAM_WAIT    = 1;
    localparam int DEF_IO_WAIT     = 0;
    localparam int DEF_ROM_TIMEOUT = 255;

    // Counter width able to hold the largest of the wait/timeout values.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/m68k_bus_responder.sv
// 68K bus-cycle responder: decodes the target of each AS cycle and paces DTACK
// for program ROM (SDRAM handshake), work/sprite RAM, Z80 shared RAM and I/O.
module m68k_bus_responder
    import rallybike_pkg::*;
#(
    parameter int RAM_WAIT    = DEF_RAM_WAIT,
    parameter int IO_WAIT     = DEF_IO_WAIT,
    parameter int ROM_TIMEOUT = DEF_ROM_TIMEOUT
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic cpu_as_n,
    input  logic prog_rom_cs,
    input  logic ram_cs,
    input  logic shared_ram_cs,
    input  logic io_cs,
    input  logic rom_ack,
    input  logic shared_busy,
    output logic dtack_n,
    output logic rom_req,
    output logic rom_timeout,
    output logic cycle_active
);

    localparam int CNT_W = cnt_width(RAM_WAIT, IO_WAIT, ROM_TIMEOUT);
    localparam logic [CNT_W-1:0] RAM_LOAD = CNT_W'(RAM_WAIT);
    localparam logic [CNT_W-1:0] IO_LOAD  = CNT_W'(IO_WAIT);
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(ROM_TIMEOUT);

    bus_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             as_prev;
    logic             rom_start;
    logic             rom_ack_q;
    logic             as_start;
    logic             sel_io;
    logic             rom_expire;

    assign as_start   = as_prev && !cpu_as_n;
    assign sel_io     = io_cs || !(prog_rom_cs || ram_cs || shared_ram_cs);
    assign rom_expire = (int'(cnt) + 1) >= ROM_TIMEOUT;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            as_prev      <= 1'b0;
            rom_start    <= 1'b0;
            rom_ack_q    <= 1'b0;
            dtack_n      <= 1'b1;
            rom_req      <= 1'b0;
            rom_timeout  <= 1'b0;
            cycle_active <= 1'b0;
        end else begin
            as_prev   <= cpu_as_n;
            // rom_ack is only meaningful while a fetch is outstanding
            rom_ack_q <= rom_ack && (state == ST_ROM_WAIT);
            rom_req   <= 1'b0;
            rom_start <= 1'b0;

            case (state)
                ST_IDLE: begin
                    dtack_n <= 1'b1;
                    if (rom_start) begin
                        // ROM fetch is issued one cycle after the start edge
                        if (!cpu_as_n) begin
                            state        <= ST_ROM_WAIT;
                            cnt          <= '0;
                            rom_req      <= 1'b1;
                            cycle_active <= 1'b1;
                        end
                    end else if (as_start) begin
                        if (prog_rom_cs) begin
                            rom_start <= 1'b1;
                        end else if (ram_cs) begin
                            state        <= ST_COUNT;
                            cnt          <= RAM_LOAD;
                            cycle_active <= 1'b1;
                        end else if (shared_ram_cs) begin
                            state        <= ST_SHR_WAIT;
                            cycle_active <= 1'b1;
                        end else if (sel_io) begin
                            state        <= ST_COUNT;
                            cnt          <= IO_LOAD;
                            cycle_active <= 1'b1;
                        end
                    end
                end

                ST_ROM_WAIT: begin
                    if (cpu_as_n) begin
                        state        <= ST_IDLE;
                        cycle_active <= 1'b0;
                    end else if (rom_ack_q) begin
                        state   <= ST_ACK;
                        dtack_n <= 1'b0;
                    end else if (rom_expire) begin
                        // saturate at the limit so the counter never wraps
                        cnt         <= TMO_LOAD;
                        state       <= ST_ACK;
                        dtack_n     <= 1'b0;
                        rom_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_SHR_WAIT: begin
                    if (cpu_as_n) begin
                        state        <= ST_IDLE;
                        cycle_active <= 1'b0;
                    end else if (!shared_busy) begin
                        state <= ST_COUNT;
                        cnt   <= RAM_LOAD;
                    end
                end

                ST_COUNT: begin
                    if (cpu_as_n) begin
                        state        <= ST_IDLE;
                        cycle_active <= 1'b0;
                    end else if (cnt == '0) begin
                        state   <= ST_ACK;
                        dtack_n <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_ACK: begin
                    // release one edge after AS is seen high
                    if (as_prev) begin
                        state        <= ST_IDLE;
                        dtack_n      <= 1'b1;
                        cycle_active <= 1'b0;
                    end
                end

                default: begin
                    state        <= ST_IDLE;
                    dtack_n      <= 1'b1;
                    cycle_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Scoreboard bench: two responders (default timing and slow timing) share one bus;
// expected DTACK edges and ROM requests are queued and matched by a monitor.
module tb_m68k_bus_responder;

    logic clk_sys = 1'b0;
    logic reset = 1'b1;
    logic cpu_as_n = 1'b1;
    logic prog_rom_cs = 1'b0, ram_cs = 1'b0, shared_ram_cs = 1'b0, io_cs = 1'b0;
    logic rom_ack = 1'b0, shared_busy = 1'b0;
    logic [1:0] dtack_n, rom_req, rom_timeout, cycle_active;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    bit done = 1'b0;

    typedef enum int {EV_FALL, EV_RISE, EV_REQ} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       dut;
        int       at;
        logic     tmo;
    } ev_t;

    ev_t exp_q[$];
    logic [1:0] dtack_prev = 2'b11;

    // dut 0: RAM_WAIT=1 IO_WAIT=0 ROM_TIMEOUT=255; dut 1: RAM_WAIT=3 IO_WAIT=2 ROM_TIMEOUT=8
    m68k_bus_responder dut_a (
        .clk_sys(clk_sys), .reset(reset), .cpu_as_n(cpu_as_n),
        .prog_rom_cs(prog_rom_cs), .ram_cs(ram_cs), .shared_ram_cs(shared_ram_cs),
        .io_cs(io_cs), .rom_ack(rom_ack), .shared_busy(shared_busy),
        .dtack_n(dtack_n[0]), .rom_req(rom_req[0]), .rom_timeout(rom_timeout[0]),
        .cycle_active(cycle_active[0])
    );

    m68k_bus_responder #(.RAM_WAIT(3), .IO_WAIT(2), .ROM_TIMEOUT(8)) dut_b (
        .clk_sys(clk_sys), .reset(reset), .cpu_as_n(cpu_as_n),
        .prog_rom_cs(prog_rom_cs), .ram_cs(ram_cs), .shared_ram_cs(shared_ram_cs),
        .io_cs(io_cs), .rom_ack(rom_ack), .shared_busy(shared_busy),
        .dtack_n(dtack_n[1]), .rom_req(rom_req[1]), .rom_timeout(rom_timeout[1]),
        .cycle_active(cycle_active[1])
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic match_ev(input ev_kind_t kind, input int d, input logic tmo);
        int idx;
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (idx < 0 && exp_q[i].kind == kind && exp_q[i].dut == d) idx = i;
        n_cmp++;
        if (idx < 0) begin
            n_err++;
            $display("FAIL %s dut%0d: unexpected event at cycle %0d", kind.name(), d, cyc);
        end else begin
            if (exp_q[idx].at != cyc || (kind == EV_FALL && exp_q[idx].tmo !== tmo)) begin
                n_err++;
                $display("FAIL %s dut%0d: got cycle %0d rom_timeout %b, want cycle %0d rom_timeout %b",
                         kind.name(), d, cyc, tmo, exp_q[idx].at, exp_q[idx].tmo);
            end
            exp_q.delete(idx);
        end
    endtask

    // monitor: sample away from the active edge
    always @(negedge clk_sys) begin
        if (!done) begin
            for (int d = 0; d < 2; d++) begin
                if (dtack_prev[d] && !dtack_n[d]) match_ev(EV_FALL, d, rom_timeout[d]);
                if (!dtack_prev[d] && dtack_n[d]) match_ev(EV_RISE, d, rom_timeout[d]);
                if (rom_req[d] === 1'b1) match_ev(EV_REQ, d, rom_timeout[d]);
            end
            dtack_prev = dtack_n;
        end
    end

    task automatic check(input string name, input logic got, input logic want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    task automatic expect_ev(input ev_kind_t k, input int d, input int at, input logic tmo);
        ev_t e;
        e.kind = k; e.dut = d; e.at = at; e.tmo = tmo;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int k);
        while (cyc < k) @(negedge clk_sys);
    endtask

    // AS falls so that the start edge t is the next posedge
    task automatic start(input logic rom, input logic ram, input logic shr, input logic io,
                         output int t);
        @(negedge clk_sys);
        prog_rom_cs = rom; ram_cs = ram; shared_ram_cs = shr; io_cs = io;
        cpu_as_n = 1'b0;
        t = cyc + 1;
    endtask

    // AS is first sampled high at edge r
    task automatic finish_cycle(input int r);
        wait_cyc(r - 1);
        cpu_as_n = 1'b1;
        wait_cyc(r + 2);
        prog_rom_cs = 1'b0; ram_cs = 1'b0; shared_ram_cs = 1'b0; io_cs = 1'b0;
        rom_ack = 1'b0;
    endtask

    initial begin
        int t;
        wait_cyc(3);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset dtack_n dut%0d", d), dtack_n[d], 1'b1);
            check($sformatf("reset rom_req dut%0d", d), rom_req[d], 1'b0);
            check($sformatf("reset rom_timeout dut%0d", d), rom_timeout[d], 1'b0);
            check($sformatf("reset cycle_active dut%0d", d), cycle_active[d], 1'b0);
        end
        reset = 1'b0;
        wait_cyc(5);

        // I/O: dut0 acks at t+1, dut1 (IO_WAIT=2) is aborted by AS at t+3
        start(0, 0, 0, 1, t);
        expect_ev(EV_FALL, 0, t + 1, 1'b0);
        expect_ev(EV_RISE, 0, t + 4, 1'b0);
        wait_cyc(t + 1);
        check("io cycle_active dut0", cycle_active[0], 1'b1);
        check("io cycle_active dut1", cycle_active[1], 1'b1);
        finish_cycle(t + 3);

        // RAM beats io_cs; rom_ack held high must be ignored
        start(0, 1, 0, 1, t);
        rom_ack = 1'b1;
        expect_ev(EV_FALL, 0, t + 2, 1'b0);
        expect_ev(EV_RISE, 0, t + 7, 1'b0);
        expect_ev(EV_FALL, 1, t + 4, 1'b0);
        expect_ev(EV_RISE, 1, t + 7, 1'b0);
        finish_cycle(t + 6);

        // no select decodes as I/O
        start(0, 0, 0, 0, t);
        expect_ev(EV_FALL, 0, t + 1, 1'b0);
        expect_ev(EV_RISE, 0, t + 6, 1'b0);
        expect_ev(EV_FALL, 1, t + 3, 1'b0);
        expect_ev(EV_RISE, 1, t + 6, 1'b0);
        finish_cycle(t + 5);

        // ROM beats RAM; rom_ack sampled at t+6 -> dtack at t+7
        start(1, 1, 0, 0, t);
        expect_ev(EV_REQ, 0, t + 1, 1'b0);
        expect_ev(EV_REQ, 1, t + 1, 1'b0);
        expect_ev(EV_FALL, 0, t + 7, 1'b0);
        expect_ev(EV_RISE, 0, t + 11, 1'b0);
        expect_ev(EV_FALL, 1, t + 7, 1'b0);
        expect_ev(EV_RISE, 1, t + 11, 1'b0);
        wait_cyc(t + 5);
        rom_ack = 1'b1;
        wait_cyc(t + 6);
        rom_ack = 1'b0;
        finish_cycle(t + 10);

        // ROM with no ack: dut1 times out after 8 wait cycles, dut0 is aborted
        start(1, 0, 0, 0, t);
        expect_ev(EV_REQ, 0, t + 1, 1'b0);
        expect_ev(EV_REQ, 1, t + 1, 1'b0);
        expect_ev(EV_FALL, 1, t + 9, 1'b1);
        expect_ev(EV_RISE, 1, t + 13, 1'b1);
        finish_cycle(t + 12);
        check("timeout flag dut0", rom_timeout[0], 1'b0);
        check("timeout flag dut1", rom_timeout[1], 1'b1);

        // shared RAM: busy seen at edges up to t+3, free from t+4
        start(0, 0, 1, 0, t);
        shared_busy = 1'b1;
        expect_ev(EV_FALL, 0, t + 6, 1'b0);
        expect_ev(EV_RISE, 0, t + 11, 1'b0);
        expect_ev(EV_FALL, 1, t + 8, 1'b1);
        expect_ev(EV_RISE, 1, t + 11, 1'b1);
        wait_cyc(t + 3);
        shared_busy = 1'b0;
        finish_cycle(t + 10);

        // shared RAM held busy, AS released: no dtack from either
        start(0, 0, 1, 0, t);
        shared_busy = 1'b1;
        wait_cyc(t + 2);
        check("shr_wait cycle_active dut0", cycle_active[0], 1'b1);
        check("shr_wait cycle_active dut1", cycle_active[1], 1'b1);
        finish_cycle(t + 3);
        shared_busy = 1'b0;

        // reset while in ACK with AS still low
        start(0, 1, 0, 0, t);
        expect_ev(EV_FALL, 0, t + 2, 1'b0);
        expect_ev(EV_FALL, 1, t + 4, 1'b1);
        expect_ev(EV_RISE, 0, t + 6, 1'b0);
        expect_ev(EV_RISE, 1, t + 6, 1'b0);
        wait_cyc(t + 5);
        reset = 1'b1;
        wait_cyc(t + 6);
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("mid-reset dtack_n dut%0d", d), dtack_n[d], 1'b1);
            check($sformatf("mid-reset rom_timeout dut%0d", d), rom_timeout[d], 1'b0);
            check($sformatf("mid-reset cycle_active dut%0d", d), cycle_active[d], 1'b0);
        end
        wait_cyc(t + 10);
        for (int d = 0; d < 2; d++)
            check($sformatf("as-held no restart dut%0d", d), cycle_active[d], 1'b0);
        cpu_as_n = 1'b1;
        ram_cs = 1'b0;
        wait_cyc(t + 12);

        // fresh I/O cycle after AS rose again
        start(0, 0, 0, 1, t);
        expect_ev(EV_FALL, 0, t + 1, 1'b0);
        expect_ev(EV_RISE, 0, t + 5, 1'b0);
        expect_ev(EV_FALL, 1, t + 3, 1'b0);
        expect_ev(EV_RISE, 1, t + 5, 1'b0);
        finish_cycle(t + 4);

        wait_cyc(cyc + 3);
        done = 1'b1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard drain: got %0d pending events, want 0", exp_q.size());
            foreach (exp_q[i])
                $display("  pending %s dut%0d at cycle %0d", exp_q[i].kind.name(), exp_q[i].dut, exp_q[i].at);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
